rfdc_dds_streamer: RTL and testbench

Multi-sample-per-beat DDS tone generator feeding an RFDC DAC AXI4-Stream slave interface.
Runtime-programmable frequency tuning word (FTW) and amplitude.
Phase-continuous across beats. Full AXIS backpressure compliance: data is held while stalled.
Sits between the control register block (ftw/amp) and the RFDC DAC tile stream input.

---
 rtl/rfdc_dds_streamer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_rfdc_dds_streamer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rfdc_dds_streamer.sv
// rfdc_dds_streamer: multi-sample DDS tone source for an RFDC DAC AXIS input.
// Ports: clk, rst_n (sync, active-low), enable, ftw/ftw_load, amp,
//   m_axis_tdata/tvalid/tready, busy. Optional RFDC_DDS_PHASE_SYNC_EN
//   adds phase_sync (pulse, zeroes the phase base on the next advance).
module rfdc_dds_streamer #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int SAMPLES_PER_BEAT = 16,
  parameter int PHASE_WIDTH      = 32,
  parameter int LUT_ADDR_WIDTH   = 10,
  parameter int AMP_WIDTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic                   ftw_load,
  input  logic [AMP_WIDTH-1:0]   amp,
`ifdef RFDC_DDS_PHASE_SYNC_EN
  input  logic                   phase_sync,
`endif
  output logic [SAMPLE_WIDTH*SAMPLES_PER_BEAT-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   busy
);

  localparam int SW    = SAMPLE_WIDTH;
  localparam int SPB   = SAMPLES_PER_BEAT;
  localparam int PW    = PHASE_WIDTH;
  localparam int L     = LUT_ADDR_WIDTH;
  localparam int AW    = AMP_WIDTH;
  localparam int DEPTH = 1 << L;
  localparam int PRW   = SW + AW + 1;

  localparam logic [AW-1:0] AMP_UNITY =
    {1'b1, {(AW-1){1'b0}}};

  localparam real PI = 3.14159265358979323846;

  // Full-cycle sine table, rounded to nearest.
  function automatic logic signed [SW-1:0] sin_entry(
    input int idx
  );
    real x;
    x = $sin(2.0 * PI * real'(idx) / real'(DEPTH))
      * real'((2 ** (SW - 1)) - 1);
    if (x >= 0.0)
      return SW'($rtoi(x + 0.5));
    return SW'(-$rtoi(0.5 - x));
  endfunction

  logic signed [SW-1:0] lut [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_lut
    assign lut[i] = sin_entry(i);
  end

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    STOP
  } state_t;

  state_t state;

  logic          adv;
  logic          feed;
  logic          flush;
  logic          take;
  logic          sync_now;
  logic          ftw_pend;
  logic [PW-1:0] ftw_shadow;
  logic [PW-1:0] ftw_active;
  logic [PW-1:0] ftw_eff;
  logic [PW-1:0] base;
  logic [PW-1:0] base_use;
  logic [PW-1:0] base_next;
  logic [PW-1:0] ph [SPB];

  logic                 s1_v;
  logic                 s2_v;
  logic [L-1:0]         s1_addr [SPB];
  logic signed [SW-1:0] s2_lut  [SPB];

  logic [AW-1:0]         amp_eff;
  logic signed [AW:0]    amp_s;
  logic signed [PRW-1:0] prod [SPB];
  logic [SW*SPB-1:0]     beat_next;
  logic                  unused_fold;

  assign adv = !m_axis_tvalid || m_axis_tready;

`ifdef RFDC_DDS_PHASE_SYNC_EN
  logic sync_pend;

  assign sync_now = phase_sync || sync_pend;

  // A pulse seen while stalled waits for the next feed.
  always_ff @(posedge clk) begin
    if (!rst_n)
      sync_pend <= 1'b0;
    else if (feed)
      sync_pend <= 1'b0;
    else if (phase_sync)
      sync_pend <= 1'b1;
  end
`else
  assign sync_now = 1'b0;
`endif

  // feed: a new beat enters S1; flush: drop everything in flight.
  always_comb begin
    feed  = 1'b0;
    flush = 1'b0;
    case (state)
      IDLE: begin
        feed  = enable;
        flush = !enable;
      end
      FILL: begin
        feed  = enable;
        flush = !enable;
      end
      STREAM: begin
        feed  = enable && adv;
        flush = !enable && adv;
      end
      STOP: begin
        flush = m_axis_tready;
      end
      default: ;
    endcase
  end

  // IDLE copies the shadow every cycle; running states on feed.
  assign take    = feed || (state == IDLE);
  assign ftw_eff = ftw_pend ? ftw_shadow : ftw_active;

  assign base_use =
    ((state == IDLE) || sync_now) ? '0 : base;

  always_comb begin
    ph[0] = base_use;
    for (int k = 1; k < SPB; k++)
      ph[k] = ph[k-1] + ftw_eff;
  end

  assign base_next = ph[SPB-1] + ftw_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ftw_shadow <= '0;
      ftw_active <= '0;
      ftw_pend   <= 1'b0;
      base       <= '0;
    end else begin
      if (ftw_load)
        ftw_shadow <= ftw;
      // A load on a take edge is not yet in the shadow.
      if (ftw_load)
        ftw_pend <= 1'b1;
      else if (take)
        ftw_pend <= 1'b0;
      if (take)
        ftw_active <= ftw_eff;
      if (feed)
        base <= base_next;
      else if (flush)
        base <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      for (int k = 0; k < SPB; k++) begin
        s1_addr[k] <= '0;
        s2_lut[k]  <= '0;
      end
    end else begin
      if (flush) begin
        s1_v <= 1'b0;
        s2_v <= 1'b0;
      end else if (adv) begin
        s1_v <= feed;
        s2_v <= s1_v;
      end
      if (feed) begin
        for (int k = 0; k < SPB; k++)
          s1_addr[k] <= ph[k][PW-1 -: L];
      end
      if (adv) begin
        for (int k = 0; k < SPB; k++)
          s2_lut[k] <= lut[s1_addr[k]];
      end
    end
  end

  // Scale: (lut * min(amp, unity)) >>> (AW-1), floor.
  always_comb begin
    amp_eff = (amp > AMP_UNITY) ? AMP_UNITY : amp;
    amp_s   = signed'({1'b0, amp_eff});
    unused_fold = 1'b0;
    beat_next   = '0;
    for (int k = 0; k < SPB; k++) begin
      prod[k] = PRW'(s2_lut[k]) * PRW'(amp_s);
      beat_next[k*SW +: SW] = prod[k][SW+AW-2 -: SW];
      unused_fold = unused_fold
        ^ (^prod[k][AW-2:0])
        ^ (^prod[k][PRW-1:PRW-2]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      busy          <= 1'b0;
    end else begin
      if (adv && s2_v && !flush)
        m_axis_tdata <= beat_next;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= FILL;
            busy  <= 1'b1;
          end
        end
        FILL: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (s2_v) begin
            state         <= STREAM;
            m_axis_tvalid <= 1'b1;
          end
        end
        STREAM: begin
          if (!enable) begin
            if (!adv) begin
              state <= STOP;
            end else begin
              state         <= IDLE;
              m_axis_tvalid <= 1'b0;
              busy          <= 1'b0;
            end
          end else if (adv) begin
            m_axis_tvalid <= s2_v;
          end
        end
        STOP: begin
          if (m_axis_tready) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rfdc_dds_streamer.sv
// tb_rfdc_dds_streamer: directed checks of the DDS streamer.
// Expected samples come from a hand-computed 8-point sine table.
module tb_rfdc_dds_streamer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [31:0]  ftw;
  logic         ftw_load;
  logic [15:0]  amp;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rfdc_dds_streamer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .ftw           (ftw),
    .ftw_load      (ftw_load),
    .amp           (amp),
`ifdef RFDC_DDS_PHASE_SYNC_EN
    .phase_sync    (1'b0),
`endif
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy)
  );

  // Sine at multiples of pi/4, scaled by 32767 and rounded.
  function automatic logic [15:0] t8(input int i);
    logic [15:0] r;
    case (i % 8)
      0, 4:    r = 16'd0;
      1, 3:    r = 16'd23170;
      2:       r = 16'd32767;
      5, 7:    r = -16'sd23170;
      default: r = -16'sd32767;
    endcase
    return r;
  endfunction

  function automatic logic [255:0] beat(
    input int start,
    input int step
  );
    logic [255:0] r;
    for (int k = 0; k < 16; k++)
      r[k*16 +: 16] = t8(start + step * k);
    return r;
  endfunction

  // Quarter-wave pattern at half amplitude, floor rounding.
  function automatic logic [255:0] half_beat();
    logic [255:0] r;
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        1:       r[k*16 +: 16] = 16'd16383;
        3:       r[k*16 +: 16] = -16'sd16384;
        default: r[k*16 +: 16] = 16'd0;
      endcase
    end
    return r;
  endfunction

  task automatic chk_b(
    input string tag,
    input logic  obs,
    input logic  exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_s(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    ftw           = 32'h0;
    ftw_load      = 1'b0;
    amp           = 16'h8000;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    chk_b("rst_tvalid", m_axis_tvalid, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_w("rst_tdata", m_axis_tdata, '0);
    rst_n = 1'b1;
    tick();

    // ftw=0: fill latency and all-zero samples
    enable = 1'b1;
    tick();
    chk_b("fill1_tvalid", m_axis_tvalid, 1'b0);
    chk_b("fill1_busy", busy, 1'b1);
    tick();
    chk_b("fill2_tvalid", m_axis_tvalid, 1'b0);
    tick();
    chk_b("fill3_tvalid", m_axis_tvalid, 1'b1);
    chk_w("ftw0_beat0", m_axis_tdata, '0);
    tick();
    chk_b("ftw0_tvalid1", m_axis_tvalid, 1'b1);
    chk_w("ftw0_beat1", m_axis_tdata, '0);

    // enable drop with tready=1 ends the stream next edge
    enable = 1'b0;
    tick();
    chk_b("off_tvalid", m_axis_tvalid, 1'b0);
    chk_b("off_busy", busy, 1'b0);

    // quarter-cycle step: 0, 32767, 0, -32767
    ftw      = 32'h4000_0000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    enable   = 1'b1;
    repeat (3) tick();
    chk_b("q_tvalid0", m_axis_tvalid, 1'b1);
    chk_w("q_beat0", m_axis_tdata, beat(0, 2));
    tick();
    chk_b("q_tvalid1", m_axis_tvalid, 1'b1);
    chk_w("q_beat1", m_axis_tdata, beat(0, 2));
    tick();
    chk_b("q_tvalid2", m_axis_tvalid, 1'b1);
    chk_w("q_beat2", m_axis_tdata, beat(0, 2));

    // amplitude: half, then clamp of 0xFFFF to unity
    amp = 16'h4000;
    tick();
    chk_w("amp_half", m_axis_tdata, half_beat());
    amp = 16'hFFFF;
    tick();
    chk_w("amp_clamp", m_axis_tdata, beat(0, 2));
    amp = 16'h8000;

    // mid-stream FTW change to an eighth-cycle step
    ftw      = 32'h2000_0000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    chk_w("ftw_old0", m_axis_tdata, beat(0, 2));
    tick();
    chk_w("ftw_old1", m_axis_tdata, beat(0, 2));
    tick();
    chk_w("ftw_old2", m_axis_tdata, beat(0, 2));
    tick();
    chk_w("ftw_new0", m_axis_tdata, beat(0, 1));
    tick();
    chk_b("ftw_new_tvalid", m_axis_tvalid, 1'b1);
    chk_w("ftw_new1", m_axis_tdata, beat(0, 1));

    enable = 1'b0;
    tick();
    chk_b("off2_tvalid", m_axis_tvalid, 1'b0);

    // beat n sample 0 sits at phase n*2^29
    ftw      = 32'h0200_0000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    enable   = 1'b1;
    repeat (3) tick();
    for (int n = 0; n < 4; n++) begin
      chk_b("pre_tvalid", m_axis_tvalid, 1'b1);
      chk_s("pre_s0", m_axis_tdata[15:0], t8(n));
      tick();
    end
    m_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_b("stall_tvalid", m_axis_tvalid, 1'b1);
      chk_s("stall_s0", m_axis_tdata[15:0], t8(4));
    end
    m_axis_tready = 1'b1;
    for (int n = 4; n < 10; n++) begin
      chk_b("post_tvalid", m_axis_tvalid, 1'b1);
      chk_s("post_s0", m_axis_tdata[15:0], t8(n));
      tick();
    end

    // STOP: beat 10 held until handshake
    m_axis_tready = 1'b0;
    enable        = 1'b0;
    tick();
    chk_b("stop_tvalid", m_axis_tvalid, 1'b1);
    chk_b("stop_busy", busy, 1'b1);
    chk_s("stop_s0", m_axis_tdata[15:0], t8(10));
    enable = 1'b1;
    tick();
    chk_b("stop_reen_tvalid", m_axis_tvalid, 1'b1);
    chk_s("stop_reen_s0", m_axis_tdata[15:0], t8(10));
    enable        = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    chk_b("stop_done_tvalid", m_axis_tvalid, 1'b0);
    chk_b("stop_done_busy", busy, 1'b0);

    // restart from phase 0, then reset mid-stream
    enable = 1'b1;
    repeat (3) tick();
    chk_b("restart_tvalid", m_axis_tvalid, 1'b1);
    chk_s("restart_s0", m_axis_tdata[15:0], t8(0));
    tick();
    chk_s("restart_b1_s0", m_axis_tdata[15:0], t8(1));
    m_axis_tready = 1'b0;
    rst_n         = 1'b0;
    tick();
    chk_b("rstmid_tvalid", m_axis_tvalid, 1'b0);
    chk_b("rstmid_busy", busy, 1'b0);
    chk_w("rstmid_tdata", m_axis_tdata, '0);
    rst_n  = 1'b1;
    enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
